// File: rtl/mm_pkg.sv
// Shared definitions for the matrix multiply engine: reduction FSM state
// encodings and the overflow-free result-width helper used by adder users.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Summing len terms of width bits never needs more than width + clog2(len) bits.
  function automatic int res_width(input int width, input int len);
    return width + $clog2(len);
  endfunction

endpackage

// File: rtl/accumulate_sequencer_adder.sv
// noOverflowAdd: registered adder. The sum appears one cycle after a and b
// are sampled. Callers size S_WIDTH so the addition cannot overflow.
module noOverflowAdd #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int S_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [S_WIDTH-1:0] sum
);

  logic [S_WIDTH-1:0] sum_d;
  logic [S_WIDTH-1:0] sum_q;

  // Combinational sum, widened to the result width before adding.
  always_comb begin
    sum_d = S_WIDTH'(a) + S_WIDTH'(b);
  end

  // Output register: one cycle of adder latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/accumulate_sequencer.sv
// accumulate_sequencer: reduces LEN unsigned terms into one overflow-free sum
// using the shared registered adder. One term is taken every two cycles
// (LOAD then ADD) so accumulator feedback never races the adder register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in LOAD; out_valid is high only in DONE and
// out_sum holds steady there until out_ready completes the transfer.
module accumulate_sequencer
  import mm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LEN       = 8,
  parameter int RES_WIDTH = res_width(WIDTH, LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [RES_WIDTH-1:0] out_sum,
  input  logic                 out_ready,
  output logic                 busy,
  output state_e               dbg_state
);

  localparam int             CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0]  LAST = CW'(LEN - 1);

  state_e               state_q, state_d;
  logic [RES_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 accept;
  logic [RES_WIDTH-1:0] add_b;
  logic [RES_WIDTH-1:0] add_sum;

  // A term is consumed only while LOAD presents in_ready.
  assign accept = (state_q == LOAD) && in_valid;
  // Feed zero unless a term is being accepted, so idle adder cycles are inert.
  assign add_b  = accept ? RES_WIDTH'(in_data) : '0;

  noOverflowAdd #(
    .A_WIDTH(RES_WIDTH),
    .B_WIDTH(RES_WIDTH),
    .S_WIDTH(RES_WIDTH)
  ) u_add (
    .clk (clk),
    .rst (rst),
    .a   (acc_q),
    .b   (add_b),
    .sum (add_sum)
  );

  // State, accumulator and term counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  // Next-state, accumulator and counter logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        acc_d   = '0;
        count_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (in_valid) state_d = ADD;
      end
      ADD: begin
        // Adder registered acc + term on the LOAD edge; capture it now.
        acc_d   = add_sum;
        count_d = count_q + CW'(1);
        state_d = (count_q == LAST) ? DONE : LOAD;
      end
      DONE: begin
        // start is deliberately not looked at here; only IDLE samples it.
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode straight from registers.
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = (state_q == DONE) ? acc_q : '0;
  assign dbg_state = state_q;

endmodule

// File: doc/accumulate_sequencer.md
# accumulate_sequencer

Sequences the shared registered adder (noOverflowAdd) to reduce a stream of LEN unsigned terms into one overflow-free sum. It is the reduction controller for one dot-product lane of the matrix multiply engine. Terms arrive on a valid/ready input port and the finished sum leaves on a valid/ready output port. Throughput is one term every two cycles, which keeps accumulator feedback through the one-cycle adder hazard-free.

## Interface
- WIDTH, 8, width of each input term (unsigned)
- LEN, 8, number of terms per reduction; LEN ≥ 1
- RES_WIDTH, WIDTH + $clog2(LEN), sum width; guarantees no overflow (LEN=1 gives RES_WIDTH=WIDTH)
- Clock  in  1  single clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high
- start  in  1  begins a reduction; sampled only in IDLE
- in_valid  in  1  in_data holds a valid term
- in_data  in  WIDTH  term value
- in_ready  out  1  block accepts a term this cycle
- out_valid  out  1  out_sum holds the finished result
- out_sum  out  RES_WIDTH  accumulated sum
- out_ready  in  1  consumer accepts out_sum
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, ADD, DONE.
- IDLE: acc = 0 and count = 0 are held. When start = 1, go to LOAD.
- LOAD: in_ready = 1. When in_valid = 1, the term is accepted. The adder sees acc and the zero-extended in_data, and the state moves to ADD.
- ADD: in_ready = 0. acc ← adder sum and count ← count + 1. If the old count == LEN-1, go to DONE; otherwise go back to LOAD.
- DONE: out_valid = 1 and out_sum = acc. When out_ready = 1, go to IDLE.
- Adder contract: noOverflowAdd, instantiated as (RES_WIDTH, RES_WIDTH, RES_WIDTH). It registers its output, so sum is valid one cycle after a and b are sampled.
- count is $clog2(LEN+1) bits wide. It is internal and does not wrap within a reduction.
- start is ignored outside IDLE. in_valid is ignored when in_ready = 0.
- If start and out_ready are both high in DONE, the block goes to IDLE and start is dropped. A new start is needed in a later cycle.
- out_sum stays stable while out_valid = 1 and out_ready = 0, for any number of cycles.
- Reset asserted at any time, including mid-reduction, forces:
  - state IDLE, acc 0, count 0;
  - all outputs 0 (in_ready, out_valid, out_sum, busy).
  - Any partial sum is discarded.

## Timing
- Outputs are registered or decoded from the state register; there is no combinational path from input to output.
- Reset values: in_ready 0, out_valid 0, out_sum 0, busy 0.
- busy rises in the cycle after the edge that samples start.
- Per term: 2 cycles (LOAD then ADD) when in_valid is held high. Gaps in in_valid stretch LOAD only.
- Latency with in_valid always high: out_valid is first seen 2·LEN rising edges after the edge that samples start. That is 16 edges for LEN=8.
- Last-term acceptance to out_valid: 2 rising edges.
- Result handoff to IDLE: 1 cycle after out_ready. The earliest next start is sampled on the edge after IDLE is entered.

## Structure
- Shared package mm_pkg holds:
  - the state encodings (IDLE=2'd0, LOAD=2'd1, ADD=2'd2, DONE=2'd3);
  - the result-width helper (WIDTH + clog2(LEN)), reused by all adder users.
- One sub-module: noOverflowAdd, the existing adder, instantiated once. Everything else is inline FSM, counter and accumulator logic.

## Test plan
- Reset then idle: hold Reset for 3 cycles and release. All outputs read 0 and in_ready stays 0 without start.
- Basic reduction, LEN=8: start, then terms 1..8 with in_valid held high. out_sum = 36, and out_valid appears 16 edges after start.
- Overflow bound, LEN=8: eight terms of 255 give out_sum = 2040, exercising bit 10.
- Input stalls: LEN=4 with terms 17, 99, 178, 78 and in_valid low for 3 cycles between terms. in_ready is high only in LOAD, out_sum = 372, and no term is lost or duplicated.
- Backpressure and restart:
  - hold out_ready low for 5 cycles; out_sum stays stable;
  - raise start together with out_ready; start is ignored;
  - start again; the second reduction of terms 10, 10, 69, 69 (LEN=4) gives 158.
- Reset mid-operation: assert Reset after 3 accepted terms. Outputs go to 0 immediately and asynchronously. A fresh start with terms 1, 3, 222, 0 (LEN=4) gives 226.
